// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
// BCD_ADJ is the +6 correction applied when a digit sum passes BCD_MAX.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result handshake bundle for bcd_serial_addsub.
// master = operand producer and result consumer, slave = the adder.
interface bcd_serial_addsub_if #(
  parameter int NDIGITS = 3
);

  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic                   cin;
  logic                   sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   result;
  logic                   cout;
  logic                   err;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, result, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, result, cout, err
  );

endinterface

// File: rtl/bcd_digit_step.sv
// Combinational single-digit BCD add cell with optional nine's complement of b.
// With BCD_INVALID_CHECK_EN defined it also flags raw operand digits above 9.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t digit,
  output logic       cout
`ifdef BCD_INVALID_CHECK_EN
  ,
  output logic       invalid
`endif
);

  bcd_digit_t b_eff;
  logic [4:0] sum;

  always_comb begin
    b_eff = sub ? (BCD_MAX - b) : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
    // The +6 correction only needs the low nibble; the carry comes from the compare.
    if (sum > {1'b0, BCD_MAX}) begin
      digit = sum[3:0] + BCD_ADJ;
      cout  = 1'b1;
    end else begin
      digit = sum[3:0];
      cout  = 1'b0;
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  assign invalid = (a > BCD_MAX) || (b > BCD_MAX);
`endif

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract, one digit per clock LSD first; result held until accepted.
// Optional BCD_INVALID_CHECK_EN adds a sticky non-BCD digit flag on err.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 3
)(
  input  logic               clk,
  input  logic               rst_n,
  bcd_serial_addsub_if.slave bus
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           sub_q, sub_d;
  logic           err_q, err_d;

  bcd_digit_t     step_digit;
  logic           step_carry;
  logic           step_invalid;

  // Operands shift right each digit, so the cell always reads the low nibble.
  bcd_digit_step u_step (
    .a     (a_q[3:0]),
    .b     (b_q[3:0]),
    .cin   (carry_q),
    .sub   (sub_q),
    .digit (step_digit),
    .cout  (step_carry)
`ifdef BCD_INVALID_CHECK_EN
    ,
    .invalid (step_invalid)
`endif
  );

`ifndef BCD_INVALID_CHECK_EN
  assign step_invalid = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    sub_d    = sub_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          carry_d  = bus.cin;
          sub_d    = bus.sub;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[4*idx_q +: 4] = step_digit;
        carry_d = step_carry;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        idx_d   = idx_q + 1'b1;
        err_d   = err_q | step_invalid;
        if (idx_q == LAST_IDX) begin
          cout_d  = step_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      sub_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      sub_q    <= sub_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
`ifdef BCD_INVALID_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed vector bench for bcd_serial_addsub (NDIGITS=3), plus hold and mid-run reset sequences.
module tb_bcd_serial_addsub;

  localparam int ND = 3;
`ifdef BCD_INVALID_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic        sub;
    logic [11:0] res;
    logic        cout;
    logic        err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  vec_t vecs[10];

  bcd_serial_addsub_if #(.NDIGITS(ND)) bus ();

  bcd_serial_addsub #(.NDIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a         = v.a;
    bus.b         = v.b;
    bus.cin       = v.cin;
    bus.sub       = v.sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(ND));
    chk({tag, " result"},  32'(bus.result), 32'(v.res));
    chk({tag, " cout"},    32'(bus.cout), 32'(v.cout));
    chk({tag, " err"},     32'(bus.err), 32'(v.err));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //         a       b       cin   sub   result  cout  err
    vecs[0] = '{12'h002, 12'h774, 1'b0, 1'b0, 12'h776, 1'b0, 1'b0};
    vecs[1] = '{12'h999, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[2] = '{12'h774, 12'h002, 1'b1, 1'b1, 12'h772, 1'b1, 1'b0};
    vecs[3] = '{12'h002, 12'h774, 1'b1, 1'b1, 12'h228, 1'b0, 1'b0};
    vecs[4] = '{12'h500, 12'h500, 1'b1, 1'b0, 12'h001, 1'b1, 1'b0};
    vecs[5] = '{12'h123, 12'h456, 1'b1, 1'b0, 12'h580, 1'b0, 1'b0};
    vecs[6] = '{12'h555, 12'h555, 1'b0, 1'b1, 12'h999, 1'b0, 1'b0};
    vecs[7] = '{12'h555, 12'h555, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0};
    vecs[8] = '{12'h00A, 12'h001, 1'b0, 1'b0, 12'h011, 1'b0, ERR_EXP};
    vecs[9] = '{12'h001, 12'h001, 1'b0, 1'b0, 12'h002, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready",  32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result",    32'(bus.result), 32'd0);
    chk("reset cout",      32'(bus.cout), 32'd0);
    chk("reset err",       32'(bus.err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Hold in DONE with out_ready low while new operands are offered.
    run_op('{12'h111, 12'h222, 1'b0, 1'b0, 12'h333, 1'b0, 1'b0}, "pre_hold");
    @(negedge clk);
    bus.a        = 12'h111;
    bus.b        = 12'h222;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    begin
      int lat;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("hold reach done", 32'(bus.out_valid), 32'd1);
    end
    for (int c = 0; c < 5; c++) begin
      bus.a        = 12'h999;
      bus.b        = 12'h999;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d result", c),    32'(bus.result), 32'h333);
      chk($sformatf("hold%0d cout", c),      32'(bus.cout), 32'd0);
      chk($sformatf("hold%0d in_ready", c),  32'(bus.in_ready), 32'd0);
      chk($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hold release out_valid", 32'(bus.out_valid), 32'd0);
    chk("hold release in_ready",  32'(bus.in_ready), 32'd1);

    // Asynchronous reset after digit 1 has been written.
    bus.a        = 12'h123;
    bus.b        = 12'h456;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun partial result", 32'(bus.result), 32'h079);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst result",    32'(bus.result), 32'd0);
    chk("async rst cout",      32'(bus.cout), 32'd0);
    chk("async rst err",       32'(bus.err), 32'd0);
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst in_ready",  32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[5], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
